// File: rtl/uart_ss_pkg.sv
// Shared types and helpers for the UART_SS subsystem.
// The TX FSM states, the idle line level and the parity function are also used by the RX side.
package uart_ss_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

  localparam logic UART_IDLE_LVL = 1'b1;

  // Callers zero-extend narrower words, so the unused upper bits do not affect the result.
  function automatic logic uart_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_ss_baud_tick.sv
// Bit-period timer: o_tick pulses for one cycle every CLKS_PER_BIT cycles.
// i_clear restarts the period so that the next tick is a full bit away.
module uart_ss_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_ss_baud_tick: CLKS_PER_BIT must be >= 2");
  end

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == LAST);

endmodule

// File: rtl/uart_ss_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// o_tx is registered and updated on the same edge as the state, so it moves only at bit boundaries.
module uart_ss_tx
  import uart_ss_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_ss_tx: DATA_BITS must be in 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_ss_tx: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_tx_state_e       state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic                 par_bit;
  logic                 tx_q;
  logic                 tick;
  logic                 accept;
  logic                 stop_last;

  assign accept    = i_valid && (state == IDLE);
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));

  // Clearing on the handshake edge aligns the first tick with the end of the start bit.
  uart_ss_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(accept),
    .o_tick (tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      tx_q     <= UART_IDLE_LVL;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            shreg    <= i_data;
            par_bit  <= uart_parity(9'(i_data), PARITY_ODD != 0);
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= ~UART_IDLE_LVL;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q  <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx_q  <= par_bit;
                state <= PARITY;
              end else begin
                tx_q  <= UART_IDLE_LVL;
                state <= STOP;
              end
            end else begin
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q  <= UART_IDLE_LVL;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_last) begin
              state <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == STOP) && stop_last && tick;

endmodule
